// File: rtl/qam_pkg.sv
// Shared constants for the 16-QAM symbol mapper: symbol size, per-axis level codes,
// amplitude values and the output-register state encoding.
package qam_pkg;

  localparam int unsigned BITS_PER_SYM = 4;

  localparam logic [1:0] CODE_00 = 2'b00;
  localparam logic [1:0] CODE_01 = 2'b01;
  localparam logic [1:0] CODE_10 = 2'b10;
  localparam logic [1:0] CODE_11 = 2'b11;

  localparam int LVL_NEG3 = -3;
  localparam int LVL_NEG1 = -1;
  localparam int LVL_POS1 = 1;
  localparam int LVL_POS3 = 3;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/qam_symbol_mapper_if.sv
// Serial-bit input and valid/ready symbol output of the QAM symbol mapper.
// slave = mapper side, master = bit source / modulator side.
interface qam_symbol_mapper_if #(
  parameter int LEVEL_W = 4
);

  logic                      bit_in;
  logic                      bit_strobe;
  logic                      align;
  logic                      sym_ready;
  logic signed [LEVEL_W-1:0] i_level;
  logic signed [LEVEL_W-1:0] q_level;
  logic                      sym_valid;
  logic                      overrun;

  modport master (
    output bit_in, bit_strobe, align, sym_ready,
    input  i_level, q_level, sym_valid, overrun
  );

  modport slave (
    input  bit_in, bit_strobe, align, sym_ready,
    output i_level, q_level, sym_valid, overrun
  );

endinterface

// File: rtl/qam_level_lut.sv
// 2-bit per-axis code to signed amplitude level (-3/-1/+1/+3, sign-extended).
// QAM_GRAY_EN selects Gray (00/01/11/10) instead of natural binary ordering.
module qam_level_lut
  import qam_pkg::*;
#(
  parameter int LEVEL_W = 4
) (
  input  logic        [1:0]         code,
  output logic signed [LEVEL_W-1:0] level
);

  int w_lvl;

  always_comb begin
    w_lvl = LVL_NEG3;
`ifdef QAM_GRAY_EN
    case (code)
      CODE_00: w_lvl = LVL_NEG3;
      CODE_01: w_lvl = LVL_NEG1;
      CODE_11: w_lvl = LVL_POS1;
      default: w_lvl = LVL_POS3;
    endcase
`else
    case (code)
      CODE_00: w_lvl = LVL_NEG3;
      CODE_01: w_lvl = LVL_NEG1;
      CODE_10: w_lvl = LVL_POS1;
      default: w_lvl = LVL_POS3;
    endcase
`endif
    level = LEVEL_W'(w_lvl);
  end

endmodule

// File: rtl/qam_symbol_mapper.sv
// Serial bit deserializer, 16-QAM I/Q mapper and valid/ready output register
// with sticky overrun. Mapping order set by QAM_GRAY_EN (see qam_level_lut).
module qam_symbol_mapper
  import qam_pkg::*;
#(
  parameter int LEVEL_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  qam_symbol_mapper_if.slave bus
);

  logic                      r_strobe_d;
  logic [1:0]                r_bit_cnt;
  logic [2:0]                r_sr;
  logic signed [LEVEL_W-1:0] r_i_level;
  logic signed [LEVEL_W-1:0] r_q_level;
  logic                      r_overrun;
  out_state_t                r_state;
  out_state_t                w_state_nxt;

  logic                      w_cap;
  logic                      w_sym_done;
  logic [3:0]                w_sym;
  logic signed [LEVEL_W-1:0] w_i_lvl;
  logic signed [LEVEL_W-1:0] w_q_lvl;
  logic                      w_load;
  logic                      w_set_ovr;

  assign w_cap      = bus.bit_strobe && !r_strobe_d;
  assign w_sym_done = w_cap && !bus.align && (r_bit_cnt == 2'(BITS_PER_SYM - 1));
  assign w_sym      = {r_sr, bus.bit_in};

  qam_level_lut #(.LEVEL_W(LEVEL_W)) u_lut_i (
    .code  (w_sym[3:2]),
    .level (w_i_lvl)
  );

  qam_level_lut #(.LEVEL_W(LEVEL_W)) u_lut_q (
    .code  (w_sym[1:0]),
    .level (w_q_lvl)
  );

  // Counter wraps 3->0 on its own, so completion needs no special-case reload
  always_ff @(posedge clock) begin
    if (reset) begin
      r_strobe_d <= 1'b0;
      r_bit_cnt  <= '0;
      r_sr       <= '0;
    end else begin
      r_strobe_d <= bus.bit_strobe;
      if (bus.align) begin
        r_bit_cnt <= '0;
        r_sr      <= '0;
      end else if (w_cap) begin
        r_bit_cnt <= r_bit_cnt + 2'd1;
        r_sr      <= {r_sr[1:0], bus.bit_in};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_set_ovr   = 1'b0;
    case (r_state)
      OUT_EMPTY: begin
        if (w_sym_done) begin
          w_load      = 1'b1;
          w_state_nxt = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (w_sym_done) begin
          if (bus.sym_ready) w_load = 1'b1;
          else               w_set_ovr = 1'b1;
        end else if (bus.sym_ready) begin
          w_state_nxt = OUT_EMPTY;
        end
      end
      default: w_state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= OUT_EMPTY;
      r_i_level <= '0;
      r_q_level <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_i_level <= w_i_lvl;
        r_q_level <= w_q_lvl;
      end
      if (w_set_ovr) r_overrun <= 1'b1;
    end
  end

  assign bus.sym_valid = (r_state == OUT_FULL);
  assign bus.i_level   = r_i_level;
  assign bus.q_level   = r_q_level;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Directed self-checking bench for qam_symbol_mapper; expectations follow QAM_GRAY_EN.
module tb_qam_symbol_mapper;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  localparam logic [3:0] E_00 = 4'hD;
  localparam logic [3:0] E_01 = 4'hF;
`ifdef QAM_GRAY_EN
  localparam logic [3:0] E_10 = 4'h3;
  localparam logic [3:0] E_11 = 4'h1;
`else
  localparam logic [3:0] E_10 = 4'h1;
  localparam logic [3:0] E_11 = 4'h3;
`endif

  qam_symbol_mapper_if #(.LEVEL_W(4)) bus ();

  qam_symbol_mapper #(.LEVEL_W(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_in     = b;
    bus.bit_strobe = 1'b1;
    tick();
    bus.bit_strobe = 1'b0;
    tick();
  endtask

  task automatic consume();
    bus.sym_ready = 1'b1;
    tick();
    bus.sym_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (bus.sym_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.sym_valid); end
    n_tests++; if (bus.i_level !== 4'h0) begin n_fail++; $display("FAIL reset_i: got %h expected 0", bus.i_level); end
    n_tests++; if (bus.q_level !== 4'h0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", bus.q_level); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", bus.overrun); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    n_tests++; if (bus.sym_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b expected 0", bus.sym_valid); end
    send_bit(1'b0);
    n_tests++; if (bus.sym_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", bus.sym_valid); end
    n_tests++; if (bus.i_level !== E_01) begin n_fail++; $display("FAIL basic_i: got %h expected %h", bus.i_level, E_01); end
    n_tests++; if (bus.q_level !== E_10) begin n_fail++; $display("FAIL basic_q: got %h expected %h", bus.q_level, E_10); end
    consume();
    n_tests++; if (bus.sym_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b expected 0", bus.sym_valid); end
    n_tests++; if (bus.i_level !== E_01) begin n_fail++; $display("FAIL basic_hold_i: got %h expected %h", bus.i_level, E_01); end
  endtask

  // Strobe already high coming out of reset counts as one edge; held high it captures once
  task automatic test_strobe_held();
    bus.bit_in     = 1'b1;
    bus.bit_strobe = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.bit_in = ~bus.bit_in;
    end
    bus.bit_strobe = 1'b0;
    tick();
    send_bit(1'b0); send_bit(1'b1);
    n_tests++; if (bus.sym_valid !== 1'b0) begin n_fail++; $display("FAIL held_early: got %b expected 0", bus.sym_valid); end
    send_bit(1'b1);
    n_tests++; if (bus.sym_valid !== 1'b1) begin n_fail++; $display("FAIL held_valid: got %b expected 1", bus.sym_valid); end
    n_tests++; if (bus.i_level !== E_10) begin n_fail++; $display("FAIL held_i: got %h expected %h", bus.i_level, E_10); end
    n_tests++; if (bus.q_level !== E_11) begin n_fail++; $display("FAIL held_q: got %h expected %h", bus.q_level, E_11); end
    consume();
  endtask

  task automatic test_overrun();
    pulse_reset();
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    n_tests++; if (bus.sym_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b expected 1", bus.sym_valid); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first_flag: got %b expected 0", bus.overrun); end
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", bus.overrun); end
    n_tests++; if (bus.i_level !== E_00) begin n_fail++; $display("FAIL ovr_keep_i: got %h expected %h", bus.i_level, E_00); end
    n_tests++; if (bus.q_level !== E_00) begin n_fail++; $display("FAIL ovr_keep_q: got %h expected %h", bus.q_level, E_00); end
    n_tests++; if (bus.sym_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", bus.sym_valid); end
    consume();
    n_tests++; if (bus.sym_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b expected 0", bus.sym_valid); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", bus.overrun); end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    bus.bit_in     = 1'b1;
    bus.bit_strobe = 1'b1;
    bus.sym_ready  = 1'b1;
    tick();
    bus.sym_ready  = 1'b0;
    bus.bit_strobe = 1'b0;
    n_tests++; if (bus.sym_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", bus.sym_valid); end
    n_tests++; if (bus.i_level !== E_11) begin n_fail++; $display("FAIL b2b_i: got %h expected %h", bus.i_level, E_11); end
    n_tests++; if (bus.q_level !== E_11) begin n_fail++; $display("FAIL b2b_q: got %h expected %h", bus.q_level, E_11); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr: got %b expected 0", bus.overrun); end
    tick();
    n_tests++; if (bus.sym_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold: got %b expected 1", bus.sym_valid); end
    consume();
  endtask

  task automatic test_align();
    send_bit(1'b1); send_bit(1'b1);
    bus.align = 1'b1;
    tick();
    bus.align = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    n_tests++; if (bus.sym_valid !== 1'b0) begin n_fail++; $display("FAIL align_early: got %b expected 0", bus.sym_valid); end
    send_bit(1'b0);
    n_tests++; if (bus.sym_valid !== 1'b1) begin n_fail++; $display("FAIL align_valid: got %b expected 1", bus.sym_valid); end
    n_tests++; if (bus.i_level !== E_10) begin n_fail++; $display("FAIL align_i: got %h expected %h", bus.i_level, E_10); end
    n_tests++; if (bus.q_level !== E_10) begin n_fail++; $display("FAIL align_q: got %h expected %h", bus.q_level, E_10); end
    consume();
    // Strobe edge coinciding with align must be discarded
    bus.align      = 1'b1;
    bus.bit_in     = 1'b1;
    bus.bit_strobe = 1'b1;
    tick();
    bus.align      = 1'b0;
    bus.bit_strobe = 1'b0;
    tick();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    n_tests++; if (bus.sym_valid !== 1'b0) begin n_fail++; $display("FAIL align_cap_early: got %b expected 0", bus.sym_valid); end
    send_bit(1'b0);
    n_tests++; if (bus.i_level !== E_00) begin n_fail++; $display("FAIL align_cap_i: got %h expected %h", bus.i_level, E_00); end
  endtask

  task automatic test_reset_mid();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    pulse_reset();
    n_tests++; if (bus.sym_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", bus.sym_valid); end
    n_tests++; if (bus.i_level !== 4'h0) begin n_fail++; $display("FAIL rmid_i: got %h expected 0", bus.i_level); end
    n_tests++; if (bus.q_level !== 4'h0) begin n_fail++; $display("FAIL rmid_q: got %h expected 0", bus.q_level); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_ovr: got %b expected 0", bus.overrun); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    n_tests++; if (bus.sym_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_early: got %b expected 0", bus.sym_valid); end
    send_bit(1'b1);
    n_tests++; if (bus.sym_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_valid2: got %b expected 1", bus.sym_valid); end
    n_tests++; if (bus.i_level !== E_01) begin n_fail++; $display("FAIL rmid_i2: got %h expected %h", bus.i_level, E_01); end
    n_tests++; if (bus.q_level !== E_01) begin n_fail++; $display("FAIL rmid_q2: got %h expected %h", bus.q_level, E_01); end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.bit_in     = 1'b0;
    bus.bit_strobe = 1'b0;
    bus.align      = 1'b0;
    bus.sym_ready  = 1'b0;
    test_reset();
    test_basic();
    test_strobe_held();
    test_overrun();
    test_back_to_back();
    test_align();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
